// File: rtl/ones_frame_stats.sv
// Frame statistics over per-word ones counts: total, max and min per frame.
// Results are held under valid/ready back-pressure while the input is stalled.
`timescale 1ns/1ps
module ones_frame_stats #(
    parameter int FRAME_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  in_ones,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_total,
    output logic [4:0]  out_max,
    output logic [4:0]  out_min,
    output logic        err
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [11:0] r_sum;
    logic [4:0]  r_max;
    logic [4:0]  r_min;
    logic [11:0] r_total;
    logic [4:0]  r_omax;
    logic [4:0]  r_omin;
    logic        r_err;

    logic [4:0]  w_c;
    logic        w_first;
    logic [11:0] w_sum;
    logic [4:0]  w_max;
    logic [4:0]  w_min;

    // First word of a frame seeds the running stats instead of folding in.
    always_comb begin
        w_c     = (in_ones > 5'd16) ? 5'd16 : in_ones;
        w_first = (r_cnt == 8'd0);
        w_sum   = (w_first ? 12'd0 : r_sum) + {7'd0, w_c};
        w_max   = (w_first || w_c > r_max) ? w_c : r_max;
        w_min   = (w_first || w_c < r_min) ? w_c : r_min;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_cnt   <= 8'd0;
            r_sum   <= 12'd0;
            r_max   <= 5'd0;
            r_min   <= 5'd0;
            r_total <= 12'd0;
            r_omax  <= 5'd0;
            r_omin  <= 5'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        if (in_ones > 5'd16)
                            r_err <= 1'b1;
                        r_sum <= w_sum;
                        r_max <= w_max;
                        r_min <= w_min;
                        if (r_cnt == LAST) begin
                            r_total <= w_sum;
                            r_omax  <= w_max;
                            r_omin  <= w_min;
                            r_cnt   <= 8'd0;
                            r_state <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready)
                        r_state <= ACCUM;
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign out_total = r_total;
    assign out_max   = r_omax;
    assign out_min   = r_omin;
    assign err       = r_err;

endmodule

// File: tb/tb_ones_frame_stats.sv
// Scoreboard bench for ones_frame_stats at FRAME_LEN=8 and FRAME_LEN=2.
// Expected frame results are queued by the stimulus and popped by monitors.
`timescale 1ns/1ps
module tb_ones_frame_stats;

    typedef struct packed {
        logic [11:0] t;
        logic [4:0]  mx;
        logic [4:0]  mn;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic [4:0]  in_ones = 5'd0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_total;
    logic [4:0]  out_max;
    logic [4:0]  out_min;
    logic        err;

    logic        in_valid2 = 1'b0;
    logic [4:0]  in_ones2 = 5'd0;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [11:0] out_total2;
    logic [4:0]  out_max2;
    logic [4:0]  out_min2;
    logic        err2;

    int checks = 0;
    int errors = 0;
    int last_stall = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    ones_frame_stats #(.FRAME_LEN(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ones(in_ones), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_total(out_total), .out_max(out_max), .out_min(out_min),
        .err(err)
    );

    ones_frame_stats #(.FRAME_LEN(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ones(in_ones2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_total(out_total2), .out_max(out_max2), .out_min(out_min2),
        .err(err2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [4:0] c);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_ones  = c;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready stuck low");
        end
        last_stall = g;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [4:0] c);
        int g;
        g = 0;
        in_valid2 = 1'b1;
        in_ones2  = c;
        while (!in_ready2 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready2) begin
            errors++;
            $display("FAIL send2_timeout: in_ready stuck low");
        end
        last_stall = g;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
    endtask

    task automatic push1(input int t, input int mx, input int mn, input int e);
        exp_t x;
        x.t = 12'(t); x.mx = 5'(mx); x.mn = 5'(mn); x.e = 1'(e);
        q1.push_back(x);
    endtask

    task automatic push2(input int t, input int mx, input int mn);
        exp_t x;
        x.t = 12'(t); x.mx = 5'(mx); x.mn = 5'(mn); x.e = 1'b0;
        q2.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!rst && out_valid) chk("hold_in_ready", int'(in_ready), 0);
        if (!rst && out_valid && out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: total %0d", out_total);
            end else begin
                x = q1.pop_front();
                chk("total", int'(out_total), int'(x.t));
                chk("max", int'(out_max), int'(x.mx));
                chk("min", int'(out_min), int'(x.mn));
                chk("err", int'(err), int'(x.e));
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (!rst && out_valid2) chk("hold_in_ready2", int'(in_ready2), 0);
        if (!rst && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result2: total %0d", out_total2);
            end else begin
                x = q2.pop_front();
                chk("total2", int'(out_total2), int'(x.t));
                chk("max2", int'(out_max2), int'(x.mx));
                chk("min2", int'(out_min2), int'(x.mn));
                chk("err2", int'(err2), 0);
            end
        end
    end

    initial begin
        logic [4:0] basic [8];
        logic [4:0] nxt [8];
        basic = '{5'd16, 5'd12, 5'd14, 5'd1, 5'd9, 5'd6, 5'd10, 5'd0};
        nxt   = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};

        #12 rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_total", int'(out_total), 0);
        chk("rst_max", int'(out_max), 0);
        chk("rst_min", int'(out_min), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk); #1;

        // Basic frame, then the same frame under back-pressure.
        push1(68, 16, 0, 0);
        for (int i = 0; i < 8; i++) send(basic[i]);
        chk("basic_latency", int'(out_valid), 1);
        push1(68, 16, 0, 0);
        send(basic[0]);
        chk("basic_gap", last_stall, 1);
        out_ready = 1'b0;
        for (int i = 1; i < 8; i++) send(basic[i]);
        chk("bp_valid_rise", int'(out_valid), 1);
        in_valid = 1'b1;
        in_ones  = 5'd3;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_total", int'(out_total), 68);
            chk("bp_max", int'(out_max), 16);
            chk("bp_min", int'(out_min), 0);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        push1(59, 11, 3, 0);
        for (int i = 0; i < 8; i++) send(nxt[i]);

        // Input bubbles.
        push1(40, 5, 5, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("bubble_early", int'(out_valid), 0);
            send(5'd5);
            if (i < 7) begin @(posedge clk); #1; end
        end
        chk("bubble_done", int'(out_valid), 1);

        // Clamp and sticky err.
        push1(30, 16, 2, 1);
        send(5'd20);
        chk("err_rise", int'(err), 1);
        for (int i = 1; i < 8; i++) send(5'd2);
        push1(32, 4, 4, 1);
        for (int i = 0; i < 8; i++) send(5'd4);
        @(posedge clk); #1;
        chk("err_sticky", int'(err), 1);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 4; i++) send(5'd9);
        #4 rst = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_total", int'(out_total), 0);
        chk("arst_max", int'(out_max), 0);
        chk("arst_min", int'(out_min), 0);
        chk("arst_err", int'(err), 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        push1(8, 1, 1, 0);
        for (int i = 0; i < 8; i++) send(5'd1);

        // Minimum frame length.
        push2(11, 7, 4);
        push2(0, 0, 0);
        send2(5'd4);
        send2(5'd7);
        chk("fl2_valid", int'(out_valid2), 1);
        send2(5'd0);
        chk("fl2_gap", last_stall, 1);
        send2(5'd0);
        chk("fl2_valid_b", int'(out_valid2), 1);
        send2(5'd0);
        chk("fl2_gap_b", last_stall, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
